// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point types, limits and saturating arithmetic helpers.
// All datapath values are signed Q(FP_WIDTH-FP_QFRAC).FP_QFRAC.
package fpga_cfg_pkg;

    localparam int unsigned FP_WIDTH = 32;
    localparam int unsigned FP_QFRAC = 16;
    localparam int unsigned FX_ACC_W = 2 * FP_WIDTH;

    typedef logic signed [FP_WIDTH-1:0] fx_t;
    typedef logic signed [FX_ACC_W-1:0] fx_acc_t;

    localparam fx_t FX_MAX = {1'b0, {(FP_WIDTH-1){1'b1}}};
    localparam fx_t FX_MIN = {1'b1, {(FP_WIDTH-1){1'b0}}};
    localparam fx_t FX_ONE = fx_t'(1) << FP_QFRAC;

    // Clamp a wide intermediate into the fx_t range.
    function automatic fx_t fx_sat(input fx_acc_t x);
        if (x > fx_acc_t'(FX_MAX)) begin
            return FX_MAX;
        end else if (x < fx_acc_t'(FX_MIN)) begin
            return FX_MIN;
        end else begin
            return fx_t'(x);
        end
    endfunction

    // Full-width product, arithmetic shift back to Q format, then saturate.
    function automatic fx_t fx_mul(input fx_t a, input fx_t b, input int unsigned qfrac);
        fx_acc_t p;
        p = fx_acc_t'(a) * fx_acc_t'(b);
        return fx_sat(p >>> qfrac);
    endfunction

    function automatic fx_t fx_add(input fx_t a, input fx_t b);
        return fx_sat(fx_acc_t'(a) + fx_acc_t'(b));
    endfunction

endpackage

// File: rtl/cont_eval.sv
// Three-stage continuation value C(S)=b0+b1*S+b2*S^2 versus payoff pipeline.
// Optional ITM_FILTER_EN: a zero payoff never exercises.
module cont_eval
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned QFRAC  = FP_QFRAC,
    parameter bit          IS_PUT = 1'b1,
    parameter fx_t         STRIKE = FX_ONE,
    parameter fx_t         DISC   = FX_ONE
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic o_ready_c,
    input  fx_t  i_s,
    input  fx_t  i_cf,
    input  fx_t  i_b0,
    input  fx_t  i_b1,
    input  fx_t  i_b2,
    input  logic i_ready,
    output logic o_valid,
    output fx_t  o_cf,
    output logic o_exercised,
    output logic o_busy_next_c
);

    logic r_v1, r_v2, r_v3;
    fx_t  r1_s2, r1_b1s, r1_pay, r1_cfd;
    fx_t  r2_b2s2, r2_lin, r2_pay, r2_cfd;
    fx_t  r3_cf;
    logic r3_ex;

    logic w_adv1, w_adv2, w_adv3;
    fx_t  w_diff, w_pay, w_s2, w_b1s, w_cfd;
    fx_t  w_b2s2, w_lin, w_c;
    logic w_ex;

    // Each stage moves when empty or when its successor moves; bubbles collapse.
    always_comb begin
        w_adv3        = !r_v3 || i_ready;
        w_adv2        = !r_v2 || w_adv3;
        w_adv1        = !r_v1 || w_adv2;
        o_ready_c     = w_adv1;
        o_busy_next_c = r_v1 || r_v2 || (r_v3 && !i_ready) || (i_valid && w_adv1);
    end

    always_comb begin
        if (IS_PUT) begin
            w_diff = fx_sat(fx_acc_t'(STRIKE) - fx_acc_t'(i_s));
        end else begin
            w_diff = fx_sat(fx_acc_t'(i_s) - fx_acc_t'(STRIKE));
        end
        w_pay = w_diff[FP_WIDTH-1] ? '0 : w_diff;
        w_s2  = fx_mul(i_s, i_s, QFRAC);
        w_b1s = fx_mul(i_b1, i_s, QFRAC);
        w_cfd = fx_mul(i_cf, DISC, QFRAC);
    end

    always_comb begin
        w_b2s2 = fx_mul(i_b2, r1_s2, QFRAC);
        w_lin  = fx_add(i_b0, r1_b1s);
        w_c    = fx_add(r2_b2s2, r2_lin);
`ifdef ITM_FILTER_EN
        w_ex   = (r2_pay > w_c) && (r2_pay != '0);
`else
        w_ex   = (r2_pay > w_c);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r1_s2  <= '0;
            r1_b1s <= '0;
            r1_pay <= '0;
            r1_cfd <= '0;
        end else if (w_adv1) begin
            r_v1 <= i_valid;
            if (i_valid) begin
                r1_s2  <= w_s2;
                r1_b1s <= w_b1s;
                r1_pay <= w_pay;
                r1_cfd <= w_cfd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r2_b2s2 <= '0;
            r2_lin  <= '0;
            r2_pay  <= '0;
            r2_cfd  <= '0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r2_b2s2 <= w_b2s2;
                r2_lin  <= w_lin;
                r2_pay  <= r1_pay;
                r2_cfd  <= r1_cfd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v3  <= 1'b0;
            r3_cf <= '0;
            r3_ex <= 1'b0;
        end else if (w_adv3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r3_cf <= w_ex ? r2_pay : r2_cfd;
                r3_ex <= w_ex;
            end
        end
    end

    assign o_valid     = r_v3;
    assign o_cf        = r3_cf;
    assign o_exercised = r3_ex;

endmodule

// File: rtl/exercise_decision.sv
// Per-date early-exercise decision: load regression beta, stream N_PATHS paths, drain.
// Optional ITM_FILTER_EN (in cont_eval) suppresses exercise of zero-payoff paths.
module exercise_decision
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned             WIDTH   = FP_WIDTH,
    parameter int unsigned             QFRAC   = FP_QFRAC,
    parameter int unsigned             N_PATHS = 10000,
    parameter bit                      IS_PUT  = 1'b1,
    parameter logic signed [WIDTH-1:0] STRIKE  = FX_ONE,
    parameter logic signed [WIDTH-1:0] DISC    = FX_ONE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    beta_valid,
    output logic                    beta_ready,
    input  logic [2:0][WIDTH-1:0]   beta,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic signed [WIDTH-1:0] s_in,
    input  logic signed [WIDTH-1:0] cf_in,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic signed [WIDTH-1:0] cf_out,
    output logic                    exercised,
    output logic                    date_done
);

    localparam int unsigned      CNT_W    = $clog2(N_PATHS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PATHS - 1);

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        DRAIN
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [2:0][WIDTH-1:0]  r_beta;
    logic                   r_beta_ready;
    logic                   r_date_done;

    logic w_beta_fire, w_in_fire, w_drained;
    logic w_run_valid, w_ce_ready, w_busy_next;

    assign w_run_valid = valid_in && (r_state == RUN);
    assign ready_out   = (r_state == RUN) && w_ce_ready;
    assign beta_ready  = r_beta_ready;
    assign date_done   = r_date_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // LOAD waits for beta, RUN takes N_PATHS paths, DRAIN empties the pipeline.
    always_comb begin
        w_state_nxt = r_state;
        w_beta_fire = 1'b0;
        w_in_fire   = 1'b0;
        w_drained   = 1'b0;
        case (r_state)
            LOAD: begin
                if (beta_valid) begin
                    w_beta_fire = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_in_fire = valid_in && w_ce_ready;
                if (w_in_fire && (r_cnt == LAST_IDX)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!w_busy_next) begin
                    w_drained   = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_beta       <= '0;
            r_beta_ready <= 1'b1;
            r_date_done  <= 1'b0;
        end else begin
            r_beta_ready <= (w_state_nxt == LOAD);
            r_date_done  <= w_drained;
            if (w_beta_fire) begin
                r_beta <= beta;
            end
            if (w_state_nxt == LOAD) begin
                r_cnt <= '0;
            end else if (w_in_fire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    cont_eval #(
        .QFRAC  (QFRAC),
        .IS_PUT (IS_PUT),
        .STRIKE (fx_t'(STRIKE)),
        .DISC   (fx_t'(DISC))
    ) u_cont_eval (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (w_run_valid),
        .o_ready_c     (w_ce_ready),
        .i_s           (fx_t'(s_in)),
        .i_cf          (fx_t'(cf_in)),
        .i_b0          (fx_t'(r_beta[0])),
        .i_b1          (fx_t'(r_beta[1])),
        .i_b2          (fx_t'(r_beta[2])),
        .i_ready       (ready_in),
        .o_valid       (valid_out),
        .o_cf          (cf_out),
        .o_exercised   (exercised),
        .o_busy_next_c (w_busy_next)
    );

endmodule

// File: tb/tb_exercise_decision.sv
// Directed + randomized bench for exercise_decision against a plain-arithmetic payoff/regression model.
module tb_exercise_decision;
    import fpga_cfg_pkg::*;

    localparam int unsigned W    = 32;
    localparam int unsigned NP   = 8;
    localparam longint      ONE  = 64'sd65536;
    localparam longint      MAXV = 64'sd2147483647;
    localparam longint      MINV = -64'sd2147483648;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  beta_valid, beta_ready;
    logic [2:0][W-1:0]     beta;
    logic                  valid_in, ready_out;
    logic signed [W-1:0]   s_in, cf_in, cf_out;
    logic                  valid_out, ready_in, exercised, date_done;

    int     checks = 0;
    int     errors = 0;
    longint bb [3];
    longint s_arr [NP];
    longint cf_arr [NP];
    longint exp_cf_q [$];
    logic   exp_ex_q [$];
    int     acc_it_q [$];

    exercise_decision #(.N_PATHS(NP)) dut (
        .clk(clk), .rst(rst),
        .beta_valid(beta_valid), .beta_ready(beta_ready), .beta(beta),
        .valid_in(valid_in), .ready_out(ready_out), .s_in(s_in), .cf_in(cf_in),
        .valid_out(valid_out), .ready_in(ready_in), .cf_out(cf_out),
        .exercised(exercised), .date_done(date_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint x);
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
    endfunction

    function automatic longint qmul(input longint a, input longint b);
        return sat((a * b) >>> 16);
    endfunction

    // Put payoff vs quadratic continuation value, all in saturating Q16.16.
    task automatic model(input longint s, input longint cf, output longint ecf, output logic eex);
        longint pay, c, cfd;
        pay = sat(ONE - s);
        if (pay < 0) pay = 0;
        c   = sat(qmul(bb[2], qmul(s, s)) + sat(bb[0] + qmul(bb[1], s)));
        cfd = qmul(cf, ONE);
        eex = (pay > c);
`ifdef ITM_FILTER_EN
        if (pay == 0) eex = 1'b0;
`endif
        ecf = eex ? pay : cfd;
    endtask

    function automatic longint rnd_s();
        return longint'($urandom_range(0, 196608)) - 32768;
    endfunction

    function automatic longint rnd_cf();
        return longint'($urandom_range(0, 2097152)) - 1048576;
    endfunction

    function automatic longint rnd_b();
        return longint'($urandom_range(0, 262144)) - 131072;
    endfunction

    task automatic fill_paths();
        for (int i = 0; i < NP; i++) begin
            s_arr[i]  = rnd_s();
            cf_arr[i] = rnd_cf();
        end
    endtask

    task automatic load_beta(input longint b0, input longint b1, input longint b2);
        bb[0] = b0; bb[1] = b1; bb[2] = b2;
        @(negedge clk);
        check("beta_ready_load", beta_ready, 1);
        beta[0] = W'(b0); beta[1] = W'(b1); beta[2] = W'(b2);
        beta_valid = 1'b1;
        valid_in   = 1'b1;
        s_in       = W'(rnd_s());
        #1;
        check("ready_out_load", ready_out, 0);
        @(negedge clk);
        beta_valid = 1'b0;
        valid_in   = 1'b0;
        check("beta_ready_run", beta_ready, 0);
    endtask

    // mode 0: ready_in always high, 1: toggling 1010..., 2: random.
    task automatic run_date(input int mode, input int budget);
        int     n_acc = 0, n_out = 0, it = 0, last_out_it = -1, n_done = 0;
        bit     done_ok = 0, in_fire, out_fire;
        longint ecf, pcf;
        logic   eex, pex;
        int     acc_it;
        exp_cf_q.delete(); exp_ex_q.delete(); acc_it_q.delete();
        while (it < budget) begin
            @(negedge clk);
            if (last_out_it >= 0 && it == last_out_it + 1) begin
                check("date_done", date_done, 1);
                check("beta_ready_after", beta_ready, 1);
                check("valid_out_after", valid_out, 0);
                done_ok = 1;
                break;
            end
            if (date_done) n_done++;
            case (mode)
                0:       ready_in = 1'b1;
                1:       ready_in = (it % 2 == 0);
                default: ready_in = 1'($urandom_range(0, 1));
            endcase
            valid_in = 1'b1;
            if (n_acc < NP) begin
                s_in  = W'(s_arr[n_acc]);
                cf_in = W'(cf_arr[n_acc]);
            end else begin
                s_in  = W'(rnd_s());
                cf_in = W'(rnd_cf());
            end
            beta_valid = (n_out < NP - 1) && ($urandom_range(0, 3) == 0);
            beta       = {$urandom, $urandom, $urandom};
            #1;
            in_fire  = valid_in && ready_out;
            out_fire = valid_out && ready_in;
            if (out_fire) begin
                if (exp_cf_q.size() == 0) begin
                    check("extra_out", valid_out, 0);
                end else begin
                    pcf    = exp_cf_q.pop_front();
                    pex    = exp_ex_q.pop_front();
                    acc_it = acc_it_q.pop_front();
                    check("cf_out", {32'h0, cf_out}, {32'h0, pcf[31:0]});
                    check("exercised", exercised, pex);
                    if (mode == 0) check("latency", 64'(it - acc_it), 3);
                end
                n_out++;
                if (n_out == NP) last_out_it = it;
            end
            if (in_fire) begin
                if (n_acc < NP) begin
                    model(s_arr[n_acc], cf_arr[n_acc], ecf, eex);
                    exp_cf_q.push_back(ecf);
                    exp_ex_q.push_back(eex);
                    acc_it_q.push_back(it);
                end
                n_acc++;
            end
            it++;
        end
        check("accepted", n_acc, NP);
        check("outputs", n_out, NP);
        check("done_early", n_done, 0);
        check("date_done_seen", done_ok, 1);
        beta_valid = 1'b0;
        valid_in   = 1'b0;
    endtask

    task automatic reset_midrun();
        int n_acc = 0, it = 0;
        bit any_out = 0, any_rdy = 0;
        load_beta(rnd_b(), rnd_b(), rnd_b());
        ready_in = 1'b1;
        while (n_acc < 4 && it < 20) begin
            @(negedge clk);
            valid_in = 1'b1;
            s_in     = W'(rnd_s());
            cf_in    = W'(rnd_cf());
            #1;
            if (ready_out) n_acc++;
            it++;
        end
        check("rst_pre_accepts", n_acc, 4);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_cf_out", {32'h0, cf_out}, 0);
        check("rst_exercised", exercised, 0);
        check("rst_date_done", date_done, 0);
        check("rst_beta_ready", beta_ready, 1);
        check("rst_ready_out", ready_out, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            #1;
            if (valid_out) any_out = 1;
            if (ready_out) any_rdy = 1;
        end
        check("post_rst_valid_out", any_out, 0);
        check("post_rst_ready_out", any_rdy, 0);
        valid_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1; beta_valid = 1'b0; beta = '0; valid_in = 1'b0;
        s_in = '0; cf_in = '0; ready_in = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_valid_out", valid_out, 0);
        check("reset_cf_out", {32'h0, cf_out}, 0);
        check("reset_exercised", exercised, 0);
        check("reset_date_done", date_done, 0);
        check("reset_beta_ready", beta_ready, 1);
        check("reset_ready_out", ready_out, 0);
        rst = 1'b0;

        // C=1.0 above payoff 0.75: continue
        fill_paths(); s_arr[0] = ONE / 4; cf_arr[0] = 19661;
        load_beta(ONE, 0, 0);
        run_date(0, 60);

        // C=0 below payoff 0.5: exercise
        fill_paths(); s_arr[0] = ONE / 2; cf_arr[0] = 6554;
        load_beta(0, 0, 0);
        run_date(0, 60);

        // tie payoff==C continues
        fill_paths(); s_arr[0] = ONE / 2;
        load_beta(ONE / 2, 0, 0);
        run_date(1, 60);

        // zero payoff with negative C
        fill_paths(); s_arr[0] = ONE + ONE / 2;
        load_beta(-ONE / 2, 0, 0);
        run_date(2, 100);

        // back-to-back with 1010 output backpressure
        fill_paths();
        load_beta(rnd_b(), rnd_b(), rnd_b());
        run_date(1, 60);

        // saturating coefficients
        fill_paths(); s_arr[0] = 100 * ONE; s_arr[1] = -100 * ONE;
        load_beta(MAXV, MAXV, MAXV);
        run_date(0, 60);

        reset_midrun();
        fill_paths();
        load_beta(rnd_b(), rnd_b(), rnd_b());
        run_date(2, 100);

        for (int d = 0; d < 4; d++) begin
            fill_paths();
            load_beta(rnd_b(), rnd_b(), rnd_b());
            run_date(2, 100);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exercise_decision.md
EXERCISE_DECISION -- requirements
Module: exercise_decision

Interface
REQ-001 SHALL have parameter WIDTH, default fpga_cfg_pkg::FP_WIDTH, fixed-point word width.
REQ-002 SHALL have parameter QFRAC, default fpga_cfg_pkg::FP_QFRAC, fractional bits.
REQ-003 SHALL have parameter N_PATHS, default 10000, paths per exercise date.
REQ-004 SHALL have parameter IS_PUT, default 1, payoff is max(K-S,0) if 1, else max(S-K,0).
REQ-005 SHALL have parameter STRIKE, default 1.0 in Q(WIDTH-QFRAC).QFRAC, strike K.
REQ-006 SHALL have parameter DISC, default 1.0 in Q format, one-step discount factor.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port beta_valid / beta_ready, in/out, 1 each, regression coefficient handshake.
REQ-010 SHALL have port beta, input, 3 x WIDTH signed, coefficients b0..b2 of C(S)=b0+b1*S+b2*S^2.
REQ-011 SHALL have port valid_in / ready_out, in/out, 1 each, path stream handshake.
REQ-012 SHALL have port s_in / cf_in, input, WIDTH signed each, spot S_t and next-date cashflow.
REQ-013 SHALL have port valid_out / ready_in, out/in, 1 each, result handshake.
REQ-014 SHALL have port cf_out, output, WIDTH signed, cashflow at this date.
REQ-015 SHALL have port exercised, output, 1, high when cf_out is the immediate payoff.
REQ-016 SHALL have port date_done, output, 1, one-cycle pulse when the date has fully drained.

Function
REQ-017 FSM states SHALL be LOAD, RUN and DRAIN; LOAD->RUN on beta_valid&&beta_ready; RUN->DRAIN when the N_PATHS-th input is accepted; DRAIN->LOAD when the pipeline is empty, pulsing date_done that cycle.
REQ-018 beta_ready SHALL be high only in LOAD; beta SHALL be latched on the accepting edge and held through RUN/DRAIN.
REQ-019 A transfer SHALL occur when valid&&ready on the same edge; ready_out = (state==RUN) && pipeline can advance.
REQ-020 The pipeline SHALL have 3 stages, latency exactly 3 cycles, throughput 1 path/cycle with no stall.
REQ-020a Stage 1 SHALL compute S^2, b1*S, payoff and cf_in*DISC.
REQ-020b Stage 2 SHALL compute b2*S^2 and b0+b1*S.
REQ-020c Stage 3 SHALL compute C and the select.
REQ-021 When valid_out && !ready_in, all stages SHALL hold; bubbles SHALL collapse, with no data loss or duplication.
REQ-022 Products SHALL be full-width, arithmetic-shifted right by QFRAC, and saturated to [FX_MIN,FX_MAX]; sums SHALL saturate.
REQ-023 exercised SHALL be (payoff > C), signed compare; cf_out = exercised ? payoff : cf_in*DISC.
REQ-024 Ties (payoff==C) SHALL continue, not exercise.
REQ-025 A path counter SHALL count accepted inputs; it SHALL reset to 0 on entering LOAD.
REQ-026 valid_in in LOAD or DRAIN SHALL be ignored (ready_out low).
REQ-026a beta_valid outside LOAD SHALL be ignored.

Reset
REQ-027 rst SHALL force state LOAD, counter 0, all stage valids 0, valid_out 0, exercised 0, date_done 0, and cf_out 0, taking effect immediately and asynchronously.
REQ-028 rst mid-date SHALL discard all in-flight paths; after release the block SHALL wait for a fresh beta.

Configuration
REQ-029 With ITM_FILTER_EN defined, paths with payoff==0 SHALL never exercise, regardless of C.
REQ-030 Without ITM_FILTER_EN, the REQ-023 compare SHALL apply to all paths, so a zero payoff exercises when C<0.

Structure
REQ-031 fx_t, FX_MAX/FX_MIN and the saturating-truncate function SHALL live in fpga_cfg_pkg.
REQ-031a The LOAD/RUN/DRAIN enum SHALL be local to the module.
REQ-032 A single sub-module, cont_eval, SHALL implement the 3-stage C(S)/payoff pipeline with a stall enable; FSM, counter and handshakes SHALL live at the top level.

Verification
REQ-033 The bench SHALL cover the following directed scenarios (WIDTH=32, QFRAC=16, put, K=1.0, DISC=1.0):
REQ-034 beta={1.0,0,0}, S=0.25, cf_in=0.3 -> payoff 0.75 < C 1.0 -> cf_out=0.3, exercised=0, 3 cycles after accept.
REQ-035 beta={0,0,0}, S=0.5, cf_in=0.1 -> payoff 0.5 > C 0 -> cf_out=0.5, exercised=1.
REQ-036 beta={0.5,0,0}, S=0.5 -> tie -> exercised=0.
REQ-036a beta={-0.5,0,0}, S=1.5 -> exercised=1 without ITM_FILTER_EN, 0 with it.
REQ-037 N_PATHS=8, back-to-back inputs, ready_in toggling 1010... -> exactly 8 outputs in order, then date_done one cycle after the last output; beta_ready then rises.
REQ-038 beta={FX_MAX,FX_MAX,FX_MAX}, S=100.0 -> C saturates to FX_MAX with no wrap.
REQ-038a rst asserted after the 4th accept -> no further valid_out, state LOAD, counter 0.
